// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - DEPTH-entry IF->ID decoupling FIFO with valid/ready handshakes and flush
module if_id_queue #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     if_valid,
   input  logic [PC_W-1:0]          if_pc,
   input  logic [INST_W-1:0]        if_inst,
   output logic                     if_ready,
   input  logic                     id_ready,
   output logic                     id_valid,
   output logic [PC_W-1:0]          id_pc,
   output logic [INST_W-1:0]        id_inst,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Storage is deliberately left unreset; occupancy is tracked by r_count alone
   logic [PC_W-1:0]   r_mem_pc   [DEPTH];
   logic [INST_W-1:0] r_mem_inst [DEPTH];

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_push;
   logic w_pop;
   logic w_full;
   logic w_empty;

   // Handshake decode uses registered occupancy only, so if_ready never depends on id_ready
   always_comb begin
      w_full   = (r_count == FULL_CNT);
      w_empty  = (r_count == '0);
      if_ready = ~w_full;
      id_valid = ~w_empty;
      w_push   = if_valid & ~w_full & ~flush;
      w_pop    = ~w_empty & id_ready & ~flush;
   end

   // Head presentation: zero-word bubble whenever nothing is buffered
   always_comb begin
      id_pc   = '0;
      id_inst = '0;
      if (!w_empty) begin
         id_pc   = r_mem_pc[r_rd_ptr];
         id_inst = r_mem_inst[r_rd_ptr];
      end
   end

   assign count = r_count;

   // Entry write on an accepted push; pointer arithmetic wraps naturally at DEPTH
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_pc[r_wr_ptr]   <= if_pc;
         r_mem_inst[r_wr_ptr] <= if_inst;
      end
   end

   // Pointer and occupancy update; flush wins over any push or pop offered alongside it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed table-driven bench for if_id_queue
module tb_if_id_queue;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_ready;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [2:0]  count;

   int n_checks;
   int n_errors;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        rdy;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic [2:0]  e_count;
      logic        e_if_ready;
   } vec_t;

   vec_t vecs[$];

   if_id_queue #(.PC_W(32), .INST_W(32), .DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .if_valid (if_valid),
      .if_pc    (if_pc),
      .if_inst  (if_inst),
      .if_ready (if_ready),
      .id_ready (id_ready),
      .id_valid (id_valid),
      .id_pc    (id_pc),
      .id_inst  (id_inst),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [31:0] pc);
      return {16'hC0DE, pc[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic fl, input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                      input logic rdy, input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                      input logic [2:0] ecnt, input logic eifr);
      vec_t v;
      v.fl = fl; v.iv = iv; v.pc = pc; v.inst = inst; v.rdy = rdy;
      v.e_valid = ev; v.e_pc = epc; v.e_inst = einst; v.e_count = ecnt; v.e_if_ready = eifr;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0;

      // pass-through: each entry visible one cycle after its push
      add(0, 1, 32'h1000, 32'h24020001, 1, 0, 32'h0,    32'h0,        3'd0, 1);
      add(0, 1, 32'h1004, 32'h24030002, 1, 1, 32'h1000, 32'h24020001, 3'd1, 1);
      add(0, 0, 32'h0,    32'h0,        1, 1, 32'h1004, 32'h24030002, 3'd1, 1);
      add(0, 0, 32'h0,    32'h0,        0, 0, 32'h0,    32'h0,        3'd0, 1);
      // fill with ID stalled; fifth offer refused
      add(0, 1, 32'h2000, mk(32'h2000), 0, 0, 32'h0,    32'h0,        3'd0, 1);
      add(0, 1, 32'h2004, mk(32'h2004), 0, 1, 32'h2000, mk(32'h2000), 3'd1, 1);
      add(0, 1, 32'h2008, mk(32'h2008), 0, 1, 32'h2000, mk(32'h2000), 3'd2, 1);
      add(0, 1, 32'h200C, mk(32'h200C), 0, 1, 32'h2000, mk(32'h2000), 3'd3, 1);
      add(0, 1, 32'h2010, mk(32'h2010), 0, 1, 32'h2000, mk(32'h2000), 3'd4, 0);
      // drain with wrap; full queue pops without pushing
      add(0, 1, 32'h2010, mk(32'h2010), 1, 1, 32'h2000, mk(32'h2000), 3'd4, 0);
      add(0, 1, 32'h2010, mk(32'h2010), 1, 1, 32'h2004, mk(32'h2004), 3'd3, 1);
      add(0, 1, 32'h2014, mk(32'h2014), 1, 1, 32'h2008, mk(32'h2008), 3'd3, 1);
      add(0, 0, 32'h0,    32'h0,        1, 1, 32'h200C, mk(32'h200C), 3'd3, 1);
      add(0, 0, 32'h0,    32'h0,        1, 1, 32'h2010, mk(32'h2010), 3'd2, 1);
      add(0, 0, 32'h0,    32'h0,        1, 1, 32'h2014, mk(32'h2014), 3'd1, 1);
      add(0, 0, 32'h0,    32'h0,        1, 0, 32'h0,    32'h0,        3'd0, 1);
      // flush at count 3 alongside push and pop offers
      add(0, 1, 32'h3100, mk(32'h3100), 0, 0, 32'h0,    32'h0,        3'd0, 1);
      add(0, 1, 32'h3104, mk(32'h3104), 0, 1, 32'h3100, mk(32'h3100), 3'd1, 1);
      add(0, 1, 32'h3108, mk(32'h3108), 0, 1, 32'h3100, mk(32'h3100), 3'd2, 1);
      add(1, 1, 32'h3000, mk(32'h3000), 1, 1, 32'h3100, mk(32'h3100), 3'd3, 1);
      add(0, 0, 32'h0,    32'h0,        1, 0, 32'h0,    32'h0,        3'd0, 1);
      // simultaneous push/pop at count 2, then stall stability and drain
      add(0, 1, 32'h4000, mk(32'h4000), 0, 0, 32'h0,    32'h0,        3'd0, 1);
      add(0, 1, 32'h4004, mk(32'h4004), 0, 1, 32'h4000, mk(32'h4000), 3'd1, 1);
      add(0, 1, 32'h4008, mk(32'h4008), 1, 1, 32'h4000, mk(32'h4000), 3'd2, 1);
      add(0, 0, 32'h0,    32'h0,        0, 1, 32'h4004, mk(32'h4004), 3'd2, 1);
      add(0, 0, 32'h0,    32'h0,        0, 1, 32'h4004, mk(32'h4004), 3'd2, 1);
      add(0, 0, 32'h0,    32'h0,        1, 1, 32'h4004, mk(32'h4004), 3'd2, 1);
      add(0, 0, 32'h0,    32'h0,        1, 1, 32'h4008, mk(32'h4008), 3'd1, 1);
      add(0, 0, 32'h0,    32'h0,        0, 0, 32'h0,    32'h0,        3'd0, 1);

      // initial reset, then a partial fill so the async reset has something to clear
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step();
      if_valid = 1'b1; if_pc = 32'hAAAA0000; if_inst = 32'h11111111;
      step();
      if_pc = 32'hAAAA0004; if_inst = 32'h22222222;
      step();
      if_valid = 1'b0; if_pc = '0; if_inst = '0;
      check("prefill_count", 32'(count), 32'd2);
      check("prefill_pc", id_pc, 32'hAAAA0000);
      #2;
      rst = 1'b1;
      #1;
      check("rst_valid", 32'(id_valid), 32'd0);
      check("rst_pc", id_pc, 32'h0);
      check("rst_inst", id_inst, 32'h0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_if_ready", 32'(if_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      step();

      for (int i = 0; i < vecs.size(); i++) begin
         flush    = vecs[i].fl;
         if_valid = vecs[i].iv;
         if_pc    = vecs[i].pc;
         if_inst  = vecs[i].inst;
         id_ready = vecs[i].rdy;
         #1;
         check($sformatf("v%0d_valid", i), 32'(id_valid), 32'(vecs[i].e_valid));
         check($sformatf("v%0d_pc", i), id_pc, vecs[i].e_pc);
         check($sformatf("v%0d_inst", i), id_inst, vecs[i].e_inst);
         check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
         check($sformatf("v%0d_if_ready", i), 32'(if_ready), 32'(vecs[i].e_if_ready));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
